truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 144 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector through an external combinational DUT and checks each response against a golden truth table.
// Optional macro SWEEP_MISR_EN adds a serial CRC-16 (0x1021) signature over the sampled responses.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'hA5C3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_idx,
  output logic [15:0]       signature
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;

  logic start_ok;
  logic last_vec;
  logic settle_end;
  logic mismatch;

  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_vec   = (idx_q == {N_IN{1'b1}});
  assign settle_end = (wait_q == 4'(SETTLE - 1));
  assign mismatch   = (state_q == S_SAMPLE) && (dut_out != EXPECTED[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_SETTLE;
      S_SETTLE: if (settle_end) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last_vec ? S_DONE : S_SETTLE;
      S_DONE:   if (start_ok) state_d = S_SETTLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // pass is derived from the held count so it can only be true once the sweep is over
  always_comb begin
    busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (err_q == '0);
  end

  always_comb begin
    wait_d = wait_q;
    idx_d  = idx_q;
    err_d  = err_q;
    ffv_d  = ffv_q;
    ffi_d  = ffi_q;
    if (start_ok) begin
      wait_d = '0;
      idx_d  = '0;
      err_d  = '0;
      ffv_d  = 1'b0;
      ffi_d  = '0;
    end else if (state_q == S_SETTLE) begin
      wait_d = wait_q + 4'd1;
    end else if (state_q == S_SAMPLE) begin
      if (mismatch) begin
        err_d = err_q + (N_IN+1)'(1);
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = idx_q;
        end
      end
      if (!last_vec) begin
        idx_d  = idx_q + (N_IN)'(1);
        wait_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      idx_q  <= '0;
      err_q  <= '0;
      ffv_q  <= 1'b0;
      ffi_q  <= '0;
    end else begin
      wait_q <= wait_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      ffv_q  <= ffv_d;
      ffi_q  <= ffi_d;
    end
  end

  assign dut_in           = idx_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

`ifdef SWEEP_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic        fb;

  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[15] ^ dut_out;
    if (start_ok) begin
      sig_d = 16'hFFFF;
    end else if (state_q == S_SAMPLE) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 16'h0000;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: a table-driven model DUT is swept and results are
// compared with a reference computed directly from the truth tables (popcount, lowest mismatch, CRC).
module tb_truth_table_sweeper;

  localparam int N_IN = 4;
  localparam int SETTLE = 2;
  localparam int NV = 16;
  localparam int VCYC = SETTLE + 1;
  localparam logic [15:0] GOLD = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        first_fail_valid;
  logic [3:0]  first_fail_idx;
  logic [15:0] signature;

  logic [15:0] model_table = GOLD;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign dut_out = model_table[dut_in];

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(GOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_fail_valid(first_fail_valid),
    .first_fail_idx(first_fail_idx),
    .signature(signature)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the tables: mismatches are the set bits of tbl ^ GOLD.
  task automatic refModel(input logic [15:0] tbl, output int err, output bit ffv,
                          output int ffi, output logic [15:0] sig);
    logic [15:0] diff;
    logic        fb;
    diff = tbl ^ GOLD;
    err  = $countones(diff);
    ffv  = (diff != 16'h0);
    ffi  = 0;
    for (int i = NV - 1; i >= 0; i--) if (diff[i]) ffi = i;
`ifdef SWEEP_MISR_EN
    sig = 16'hFFFF;
    for (int i = 0; i < NV; i++) begin
      fb  = sig[15] ^ tbl[i];
      sig = {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
`else
    sig = 16'h0000;
`endif
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".dut_in"}, 32'(dut_in), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".pass"}, 32'(pass), 0);
    checkOutput({tag, ".err"}, 32'(err_count), 0);
    checkOutput({tag, ".ffv"}, 32'(first_fail_valid), 0);
    checkOutput({tag, ".ffi"}, 32'(first_fail_idx), 0);
    checkOutput({tag, ".sig"}, 32'(signature), 0);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] tbl,
                               input int restart_at, input int reset_at);
    int          e_err, e_ffi;
    bit          e_ffv;
    logic [15:0] e_sig;
    refModel(tbl, e_err, e_ffv, e_ffi, e_sig);
    model_table = tbl;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, ".k0.busy"}, 32'(busy), 1);
    checkOutput({tag, ".k0.done"}, 32'(done), 0);
    checkOutput({tag, ".k0.err"}, 32'(err_count), 0);
    checkOutput({tag, ".k0.ffv"}, 32'(first_fail_valid), 0);
    checkOutput({tag, ".k0.dut_in"}, 32'(dut_in), 0);
`ifdef SWEEP_MISR_EN
    checkOutput({tag, ".k0.sig"}, 32'(signature), 32'h0000FFFF);
`else
    checkOutput({tag, ".k0.sig"}, 32'(signature), 0);
`endif
    for (int k = 1; k <= NV * VCYC; k++) begin
      @(posedge clk);
      #1;
      start = (k == restart_at);
      if (k < NV * VCYC) begin
        checkOutput($sformatf("%s.k%0d.dut_in", tag, k), 32'(dut_in), 32'(k / VCYC));
        checkOutput($sformatf("%s.k%0d.done", tag, k), 32'(done), 0);
        checkOutput($sformatf("%s.k%0d.busy", tag, k), 32'(busy), 1);
      end
      if (k == reset_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkReset({tag, ".async_rst"});
        @(negedge clk);
        @(negedge clk);
        checkReset({tag, ".rst_hold"});
        rst_n = 1'b1;
        return;
      end
    end
    for (int h = 0; h < 3; h++) begin
      checkOutput($sformatf("%s.end%0d.done", tag, h), 32'(done), 1);
      checkOutput($sformatf("%s.end%0d.busy", tag, h), 32'(busy), 0);
      checkOutput($sformatf("%s.end%0d.pass", tag, h), 32'(pass), 32'(e_err == 0));
      checkOutput($sformatf("%s.end%0d.err", tag, h), 32'(err_count), 32'(e_err));
      checkOutput($sformatf("%s.end%0d.ffv", tag, h), 32'(first_fail_valid), 32'(e_ffv));
      checkOutput($sformatf("%s.end%0d.ffi", tag, h), 32'(first_fail_idx), 32'(e_ffi));
      checkOutput($sformatf("%s.end%0d.sig", tag, h), 32'(signature), 32'(e_sig));
      checkOutput($sformatf("%s.end%0d.dut_in", tag, h), 32'(dut_in), 32'(NV - 1));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] rnd;
    #1;
    checkReset("por");
    #12;
    rst_n = 1'b1;

    applyStimulus("golden", GOLD, -1, -1);
    applyStimulus("restart10", GOLD, 10, -1);
    applyStimulus("from_done", GOLD, -1, -1);
    applyStimulus("stuck0", 16'h0000, -1, -1);
    checkOutput("stuck0.err_const", 32'(err_count), 8);
    checkOutput("stuck0.ffi_const", 32'(first_fail_idx), 0);
    applyStimulus("stuck1", 16'hFFFF, -1, -1);
    checkOutput("stuck1.err_const", 32'(err_count), 8);
    checkOutput("stuck1.ffi_const", 32'(first_fail_idx), 2);
    applyStimulus("reset20", 16'h0000, -1, 20);
    applyStimulus("after_rst", GOLD, -1, -1);
    for (int r = 0; r < 4; r++) begin
      rnd = 16'($urandom);
      applyStimulus($sformatf("rand%0d", r), GOLD ^ rnd, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
